// File: rtl/pipe_hazard_sb.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_sb
//  Purpose  : Scoreboard hazard/forwarding unit beside the ID-stage decoder.
//             Tracks each in-flight register write by age and remaining
//             latency. Produces the ID stall, the issue strobe and the
//             operand forwarding selects.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_sb #(
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter int FWD_DEPTH = 3,
    parameter int SW        = 2,
    parameter int LD_LAT    = 1,
    parameter int MUL_LAT   = 2,
    parameter int CW        = 2
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_wreg,
    input  logic [AW-1:0] id_rd,
    input  logic [1:0]    id_class,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic          sb_busy
);

    localparam logic [SW-1:0] c_depth   = SW'(FWD_DEPTH);
    localparam logic [CW-1:0] c_ld_lat  = CW'(LD_LAT);
    localparam logic [CW-1:0] c_mul_lat = CW'(MUL_LAT);

    // Current table contents; entry 0 is hardwired empty so r0 never hazards.
    logic [SW-1:0] w_age [NREG];
    logic [CW-1:0] w_cnt [NREG];

    logic [CW-1:0] w_lat;
    logic          w_rs_live;
    logic          w_rt_live;
    logic          w_haz_a;
    logic          w_haz_b;
    logic          w_write;

    assign w_age[0] = '0;
    assign w_cnt[0] = '0;

    // Stall cycles the issuing producer imposes on its consumers.
    always_comb begin
        w_lat = '0;
        case (id_class)
            2'b01:   w_lat = c_ld_lat;
            2'b10:   w_lat = c_mul_lat;
            default: w_lat = '0;
        endcase
    end

    // Lookups use pre-update state, so an instruction reading its own rd
    // sees the older producer.
    assign w_rs_live = id_rs_used && (id_rs != '0);
    assign w_rt_live = id_rt_used && (id_rt != '0);
    assign w_haz_a   = w_rs_live && (w_cnt[id_rs] != '0);
    assign w_haz_b   = w_rt_live && (w_cnt[id_rt] != '0);

    assign stall   = id_valid && !flush && (w_haz_a || w_haz_b);
    assign issue   = id_valid && !flush && !stall;
    assign fwd_a   = w_rs_live ? w_age[id_rs] : '0;
    assign fwd_b   = w_rt_live ? w_age[id_rt] : '0;
    assign w_write = issue && id_wreg && (id_rd != '0);

    // Busy whenever any register still has a write in its forwarding window.
    always_comb begin
        sb_busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            sb_busy = sb_busy | (w_age[r] != '0);
        end
    end

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic [SW-1:0] r_age_q;
        logic [SW-1:0] w_age_d;
        logic [CW-1:0] r_cnt_q;
        logic [CW-1:0] w_cnt_d;

        // Age the entry each cycle; a new producer for this register wins.
        always_comb begin
            w_age_d = r_age_q;
            w_cnt_d = r_cnt_q;
            if (r_age_q != '0) begin
                if (r_age_q == c_depth) begin
                    w_age_d = '0;
                    w_cnt_d = '0;
                end else begin
                    w_age_d = r_age_q + SW'(1);
                    w_cnt_d = (r_cnt_q != '0) ? (r_cnt_q - CW'(1)) : '0;
                end
            end
            if (w_write && (id_rd == AW'(r))) begin
                w_age_d = SW'(1);
                w_cnt_d = w_lat;
            end
        end

        // Table storage; reset drops all in-flight tracking at once.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_age_q <= '0;
                r_cnt_q <= '0;
            end else begin
                r_age_q <= w_age_d;
                r_cnt_q <= w_cnt_d;
            end
        end

        assign w_age[r] = r_age_q;
        assign w_cnt[r] = r_cnt_q;
    end

endmodule
`default_nettype wire
